// File: rtl/ultra_pkg.sv
// Shared types and constants for the transmit pulse generator channel.
package ultra_pkg;

  localparam int unsigned CFG_W_DEFAULT = 8;

  // A half-period of zero would give a zero-width pulse; it runs as one cycle instead.
  localparam int unsigned HALF_MIN = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_POS,
    ST_NEG,
    ST_DAMP,
    ST_DONE
  } tx_state_t;

endpackage

// File: rtl/tx_pulse_gen_if.sv
// Control/config and pulser-drive bundle between a channel controller and one tx_pulse_gen.
interface tx_pulse_gen_if #(
  parameter int unsigned CFG_W = ultra_pkg::CFG_W_DEFAULT
);
  logic             start;
  logic             abort;
  logic [CFG_W-1:0] delay;
  logic [CFG_W-1:0] num_cycles;
  logic [CFG_W-1:0] half_period;
  logic [CFG_W-1:0] damp_cycles;
  logic             tx_pos;
  logic             tx_neg;
  logic             damp;
  logic             rx_trig;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, delay, num_cycles, half_period, damp_cycles,
    input  tx_pos, tx_neg, damp, rx_trig, busy, done
  );

  modport slave (
    input  start, abort, delay, num_cycles, half_period, damp_cycles,
    output tx_pos, tx_neg, damp, rx_trig, busy, done
  );
endinterface

// File: rtl/tx_pulse_gen_cnt.sv
// Loadable down-counter that stops at zero; load wins over enable.
module cfg_down_counter #(
  parameter int unsigned CFG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CFG_W-1:0] load_val,
  input  logic             en,
  output logic             zero,
  output logic             last
);
  logic [CFG_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CFG_W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == CFG_W'(1));
endmodule

// File: rtl/tx_pulse_gen.sv
// Per-element transmit sequencer: fire delay, bipolar burst, damping, with rx time-zero marker.
module tx_pulse_gen
  import ultra_pkg::*;
#(
  parameter int unsigned CFG_W = CFG_W_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  tx_pulse_gen_if.slave bus
);
  tx_state_t state, state_nx;

  logic [CFG_W-1:0] half_q;
  logic [CFG_W-1:0] half_in;
  logic [CFG_W-1:0] half_load_val;
  logic             accept;
  logic             pos_armed;

  logic dly_en, dly_zero, dly_last;
  logic half_load, half_en, half_zero, half_last;
  logic cyc_en, cyc_zero, cyc_last;
  logic dmp_en, dmp_zero, dmp_last;
  logic unused_flags;

  logic tx_pos_q, tx_neg_q, damp_q, rx_trig_q, busy_q, done_q;

  assign half_in = (bus.half_period == '0) ? CFG_W'(HALF_MIN) : bus.half_period;
  assign accept  = (state == ST_IDLE) && bus.start && !bus.abort;

  cfg_down_counter #(.CFG_W(CFG_W)) u_dly_cnt (
    .clk(clk), .reset(reset), .load(accept), .load_val(bus.delay),
    .en(dly_en), .zero(dly_zero), .last(dly_last)
  );

  cfg_down_counter #(.CFG_W(CFG_W)) u_half_cnt (
    .clk(clk), .reset(reset), .load(half_load), .load_val(half_load_val),
    .en(half_en), .zero(half_zero), .last(half_last)
  );

  cfg_down_counter #(.CFG_W(CFG_W)) u_cyc_cnt (
    .clk(clk), .reset(reset), .load(accept), .load_val(bus.num_cycles),
    .en(cyc_en), .zero(cyc_zero), .last(cyc_last)
  );

  cfg_down_counter #(.CFG_W(CFG_W)) u_dmp_cnt (
    .clk(clk), .reset(reset), .load(accept), .load_val(bus.damp_cycles),
    .en(dmp_en), .zero(dmp_zero), .last(dmp_last)
  );

  assign unused_flags = &{1'b0, dly_zero, half_zero};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      half_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) half_q <= half_in;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = (bus.delay != '0) ? ST_DELAY : ST_POS;
      ST_DELAY: if (dly_last) state_nx = ST_POS;
      // With N=0 the single POS cycle carries only rx_trig, then the burst is skipped.
      ST_POS: begin
        if (cyc_zero)       state_nx = dmp_zero ? ST_DONE : ST_DAMP;
        else if (half_last) state_nx = ST_NEG;
      end
      ST_NEG: begin
        if (half_last) begin
          if (cyc_last) state_nx = dmp_zero ? ST_DONE : ST_DAMP;
          else          state_nx = ST_POS;
        end
      end
      ST_DAMP:  if (dmp_last) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if ((state != ST_IDLE) && bus.abort) state_nx = ST_IDLE;
  end

  always_comb begin
    dly_en        = (state == ST_DELAY);
    half_en       = (state == ST_POS) || (state == ST_NEG);
    half_load     = ((state_nx == ST_POS) && (state != ST_POS)) ||
                    ((state_nx == ST_NEG) && (state != ST_NEG));
    half_load_val = (state == ST_IDLE) ? half_in : half_q;
    cyc_en        = (state == ST_NEG) && half_last;
    dmp_en        = (state == ST_DAMP);
    // Cycle counter is loaded on the accept edge, so from IDLE look at the input directly.
    pos_armed     = (state == ST_IDLE) ? (bus.num_cycles != '0) : !cyc_zero;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_pos_q  <= 1'b0;
      tx_neg_q  <= 1'b0;
      damp_q    <= 1'b0;
      rx_trig_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tx_pos_q  <= (state_nx == ST_POS) && pos_armed;
      tx_neg_q  <= (state_nx == ST_NEG);
      damp_q    <= (state_nx == ST_DAMP);
      rx_trig_q <= (state_nx == ST_POS) && ((state == ST_IDLE) || (state == ST_DELAY));
      busy_q    <= (state_nx != ST_IDLE);
      done_q    <= (state_nx == ST_DONE);
    end
  end

  assign bus.tx_pos  = tx_pos_q;
  assign bus.tx_neg  = tx_neg_q;
  assign bus.damp    = damp_q;
  assign bus.rx_trig = rx_trig_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
